// File: rtl/qlf_k4n8_gpio_ctrl.sv
// GPIO bank controller: register file driving bidir pad cells, synchronized input edge capture, W1C interrupt status.
// Latency: register reads 1 cycle; pad outputs update 1 cycle after write; pad edge to STATUS SYNC_STAGES+1 cycles, irq one more.
// Backpressure: none; a read or write is accepted every cycle and rd_valid always follows rd_en by exactly one cycle.
module qlf_k4n8_gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_en,
  input  logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  // Settle window covers the synchronizer depth plus the prev stage.
  localparam int             CNT_W       = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [CNT_W-1:0] settle;

  logic             wr_out;
  logic             wr_dir;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_status;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_mux;

  // DIR is held inverted so gpio_en itself is the stored register.
  assign dir = ~gpio_en;
  assign s   = sync_q[SYNC_STAGES-1];

  assign wr_out    = wr_en && (addr == ADDR_OUT);
  assign wr_dir    = wr_en && (addr == ADDR_DIR);
  assign wr_rise   = wr_en && (addr == ADDR_RISE_EN);
  assign wr_fall   = wr_en && (addr == ADDR_FALL_EN);
  assign wr_status = wr_en && (addr == ADDR_STATUS);

  // Only pads currently configured as inputs can report edges.
  assign rise       = s & ~prev & rise_en & gpio_en;
  assign fall       = ~s & prev & fall_en & gpio_en;
  assign status_set = (settle == '0) ? (rise | fall) : '0;
  assign status_clr = wr_status ? wdata : '0;

  // Register read mux; sees pre-write state so same-cycle read returns the old value.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_OUT:     rd_mux = gpio_in;
      ADDR_DIR:     rd_mux = dir;
      ADDR_IN:      rd_mux = s;
      ADDR_RISE_EN: rd_mux = rise_en;
      ADDR_FALL_EN: rd_mux = fall_en;
      ADDR_STATUS:  rd_mux = status;
      default:      rd_mux = '0;
    endcase
  end

  // Input synchronizer chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= gpio_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s;
    end
  end

  // Control registers; the pad drive/direction outputs are the registers themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_in <= '0;
      gpio_en <= '1;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (wr_out)  gpio_in <= wdata;
      if (wr_dir)  gpio_en <= ~wdata;
      if (wr_rise) rise_en <= wdata;
      if (wr_fall) fall_en <= wdata;
    end
  end

  // Settle counter masks edges after reset and after any direction change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= SETTLE_LOAD;
    end else if (wr_dir) begin
      settle <= SETTLE_LOAD;
    end else if (settle != '0) begin
      settle <= settle - CNT_W'(1);
    end
  end

  // Sticky status with write-1-to-clear; a new edge in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else begin
      status <= (status & ~status_clr) | status_set;
    end
  end

  // Level interrupt registered from the status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |status;
    end
  end

  // Registered read port; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_qlf_k4n8_gpio_ctrl.sv
// Bench for qlf_k4n8_gpio_ctrl: directed scenarios followed by randomized traffic against a behavioural model.
// Model holds register contents plus a history of pad samples; status follows the edge/settle rules directly.
// Pads modelled as bidir cells: gpio_out is the external level masked by gpio_en.
module tb_qlf_k4n8_gpio_ctrl;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic         rd_en;
  logic [2:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         rd_valid;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_en;
  logic [W-1:0] gpio_out;
  logic         irq;
  logic [W-1:0] pad_ext;

  int vec;
  int miss;

  // Behavioural model state
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_rdata;
  logic         m_irq, m_rvld;
  logic [W-1:0] m_h [0:S];
  int           m_age;

  qlf_k4n8_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .gpio_in(gpio_in),
    .gpio_en(gpio_en), .gpio_out(gpio_out), .irq(irq)
  );

  assign gpio_out = pad_ext & gpio_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
    m_rdata = '0; m_irq = 1'b0; m_rvld = 1'b0; m_age = 0;
    for (int j = 0; j <= S; j++) m_h[j] = '0;
  endtask

  // Apply one clock of stimulus, advance the model by one edge, return #1 after the edge.
  task automatic cyc(input logic w, input logic r, input logic [2:0] a, input logic [W-1:0] d);
    logic [W-1:0] sv, pv, setv, rdv, clrv, samp;
    wr_en = w; rd_en = r; addr = a; wdata = d;
    samp = pad_ext & ~m_dir;
    sv = m_h[S-1];
    pv = m_h[S];
    setv = (m_age >= S + 1) ? (((sv & ~pv & m_rise) | (~sv & pv & m_fall)) & ~m_dir) : '0;
    case (a)
      3'd0: rdv = m_out;
      3'd1: rdv = m_dir;
      3'd2: rdv = sv;
      3'd3: rdv = m_rise;
      3'd4: rdv = m_fall;
      3'd5: rdv = m_status;
      default: rdv = '0;
    endcase
    clrv = (w && a == 3'd5) ? d : '0;
    m_irq = |m_status;
    m_rvld = r;
    if (r) m_rdata = rdv;
    m_status = (m_status & ~clrv) | setv;
    if (w && a == 3'd0) m_out = d;
    if (w && a == 3'd3) m_rise = d;
    if (w && a == 3'd4) m_fall = d;
    if (w && a == 3'd1) begin
      m_dir = d;
      m_age = 0;
    end else if (m_age < 1000) begin
      m_age = m_age + 1;
    end
    for (int j = S; j > 0; j--) m_h[j] = m_h[j-1];
    m_h[0] = samp;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic test_reset();
    pad_ext = 8'hFF;
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (gpio_en !== 8'hFF) begin miss++; $display("FAIL reset_gpio_en got %h want %h", gpio_en, 8'hFF); end
    vec++; if (gpio_in !== 8'h00) begin miss++; $display("FAIL reset_gpio_in got %h want %h", gpio_in, 8'h00); end
    vec++; if (rd_valid !== 1'b0) begin miss++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL reset_rdata got %h want 00", rdata); end
    rst_n = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 3'd3, 8'hFF);
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL reset_irq got %b want 0", irq); end
    idle(10);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL reset_no_false_edge status got %h want 00", rdata); end
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL reset_irq_after got %b want 0", irq); end
    cyc(1'b0, 1'b1, 3'd2, '0);
    vec++; if (rdata !== 8'hFF) begin miss++; $display("FAIL reset_in_reg got %h want FF", rdata); end
  endtask

  task automatic test_output_drive();
    cyc(1'b1, 1'b0, 3'd1, 8'h0F);
    vec++; if (gpio_en !== 8'hF0) begin miss++; $display("FAIL drive_gpio_en got %h want F0", gpio_en); end
    cyc(1'b1, 1'b0, 3'd0, 8'hA5);
    vec++; if (gpio_in !== 8'hA5) begin miss++; $display("FAIL drive_gpio_in got %h want A5", gpio_in); end
    cyc(1'b0, 1'b1, 3'd0, '0);
    vec++; if (rd_valid !== 1'b1) begin miss++; $display("FAIL drive_rd_valid got %b want 1", rd_valid); end
    vec++; if (rdata !== 8'hA5) begin miss++; $display("FAIL drive_rdata got %h want A5", rdata); end
    idle(1);
    vec++; if (rd_valid !== 1'b0) begin miss++; $display("FAIL drive_rd_valid_drop got %b want 0", rd_valid); end
    vec++; if (rdata !== 8'hA5) begin miss++; $display("FAIL drive_rdata_hold got %h want A5", rdata); end
    cyc(1'b0, 1'b1, 3'd2, '0);
    vec++; if (rdata !== 8'hF0) begin miss++; $display("FAIL drive_in_masked got %h want F0", rdata); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 3'd3, 8'h5A);
    cyc(1'b1, 1'b0, 3'd4, 8'hC3);
    cyc(1'b1, 1'b1, 3'd0, 8'h3C);
    vec++; if (rdata !== 8'hA5) begin miss++; $display("FAIL b2b_read_pre_write got %h want A5", rdata); end
    vec++; if (gpio_in !== 8'h3C) begin miss++; $display("FAIL b2b_write_gpio_in got %h want 3C", gpio_in); end
    cyc(1'b0, 1'b1, 3'd3, '0);
    vec++; if (rdata !== 8'h5A || rd_valid !== 1'b1) begin miss++; $display("FAIL b2b_rise_en got %h/%b want 5A/1", rdata, rd_valid); end
    cyc(1'b0, 1'b1, 3'd4, '0);
    vec++; if (rdata !== 8'hC3 || rd_valid !== 1'b1) begin miss++; $display("FAIL b2b_fall_en got %h/%b want C3/1", rdata, rd_valid); end
    cyc(1'b1, 1'b1, 3'd6, 8'hFF);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL b2b_addr6 got %h want 00", rdata); end
    cyc(1'b0, 1'b1, 3'd6, '0);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL b2b_addr6_after_write got %h want 00", rdata); end
    cyc(1'b0, 1'b1, 3'd1, '0);
    vec++; if (rdata !== 8'h0F) begin miss++; $display("FAIL b2b_dir got %h want 0F", rdata); end
  endtask

  task automatic test_rise();
    cyc(1'b1, 1'b0, 3'd3, 8'h01);
    cyc(1'b1, 1'b0, 3'd4, 8'h00);
    pad_ext = 8'h00;
    cyc(1'b1, 1'b0, 3'd1, 8'h00);
    idle(8);
    cyc(1'b1, 1'b0, 3'd5, 8'hFF);
    idle(2);
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL rise_irq_clear got %b want 0", irq); end
    pad_ext = 8'h01;
    cyc(1'b0, 1'b0, 3'd0, '0);
    cyc(1'b0, 1'b0, 3'd0, '0);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL rise_status_early got %h want 00", rdata); end
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL rise_irq_early got %b want 0", irq); end
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h01) begin miss++; $display("FAIL rise_status_t3 got %h want 01", rdata); end
    vec++; if (irq !== 1'b1) begin miss++; $display("FAIL rise_irq_t4 got %b want 1", irq); end
  endtask

  task automatic test_w1c_race();
    cyc(1'b1, 1'b0, 3'd3, 8'h03);
    cyc(1'b1, 1'b0, 3'd4, 8'h01);
    pad_ext = 8'h03;
    idle(5);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h03) begin miss++; $display("FAIL w1c_setup got %h want 03", rdata); end
    pad_ext = 8'h02;
    cyc(1'b0, 1'b0, 3'd0, '0);
    cyc(1'b0, 1'b0, 3'd0, '0);
    cyc(1'b1, 1'b0, 3'd5, 8'h01);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h03) begin miss++; $display("FAIL w1c_set_wins got %h want 03", rdata); end
    cyc(1'b1, 1'b0, 3'd5, 8'h03);
    vec++; if (irq !== 1'b1) begin miss++; $display("FAIL w1c_irq_lag got %b want 1", irq); end
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL w1c_cleared got %h want 00", rdata); end
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL w1c_irq_cleared got %b want 0", irq); end
  endtask

  task automatic test_turnaround();
    cyc(1'b1, 1'b0, 3'd4, 8'h00);
    cyc(1'b1, 1'b0, 3'd1, 8'h04);
    pad_ext = 8'h06;
    cyc(1'b1, 1'b0, 3'd3, 8'h04);
    idle(5);
    cyc(1'b1, 1'b0, 3'd5, 8'hFF);
    idle(2);
    cyc(1'b1, 1'b0, 3'd1, 8'h00);
    idle(8);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h00) begin miss++; $display("FAIL turn_suppressed got %h want 00", rdata); end
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL turn_irq got %b want 0", irq); end
    pad_ext = 8'h02;
    idle(5);
    pad_ext = 8'h06;
    idle(5);
    cyc(1'b0, 1'b1, 3'd5, '0);
    vec++; if (rdata !== 8'h04) begin miss++; $display("FAIL turn_real_edge got %h want 04", rdata); end
    vec++; if (irq !== 1'b1) begin miss++; $display("FAIL turn_real_irq got %b want 1", irq); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 3'd1, 8'h0F);
    vec++; if (gpio_en !== 8'hF0 || irq !== 1'b1) begin miss++; $display("FAIL areset_pre got %h/%b want F0/1", gpio_en, irq); end
    cyc(1'b0, 1'b1, 3'd0, '0);
    vec++; if (rd_valid !== 1'b1) begin miss++; $display("FAIL areset_pre_valid got %b want 1", rd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (rd_valid !== 1'b0) begin miss++; $display("FAIL areset_rd_valid got %b want 0", rd_valid); end
    vec++; if (gpio_en !== 8'hFF) begin miss++; $display("FAIL areset_gpio_en got %h want FF", gpio_en); end
    vec++; if (irq !== 1'b0) begin miss++; $display("FAIL areset_irq got %b want 0", irq); end
    vec++; if (gpio_in !== 8'h00) begin miss++; $display("FAIL areset_gpio_in got %h want 00", gpio_in); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic         w, r;
    logic [2:0]   a;
    logic [W-1:0] d;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) pad_ext = pad_ext ^ W'(1 << $urandom_range(0, W - 1));
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      a = 3'($urandom_range(0, 7));
      d = W'($urandom);
      if (w && a == 3'd1 && $urandom_range(0, 5) != 0) w = 1'b0;
      if (a == 3'd1) d = d & 8'h0F;
      cyc(w, r, a, d);
      vec++; if (gpio_in !== m_out) begin miss++; $display("FAIL rand_gpio_in n=%0d got %h want %h", n, gpio_in, m_out); end
      vec++; if (gpio_en !== ~m_dir) begin miss++; $display("FAIL rand_gpio_en n=%0d got %h want %h", n, gpio_en, ~m_dir); end
      vec++; if (irq !== m_irq) begin miss++; $display("FAIL rand_irq n=%0d got %b want %b", n, irq, m_irq); end
      vec++; if (rd_valid !== m_rvld) begin miss++; $display("FAIL rand_rd_valid n=%0d got %b want %b", n, rd_valid, m_rvld); end
      vec++; if (rdata !== m_rdata) begin miss++; $display("FAIL rand_rdata n=%0d got %h want %h", n, rdata, m_rdata); end
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    model_reset();
    test_reset();
    test_output_drive();
    test_back_to_back();
    test_rise();
    test_w1c_race();
    test_turnaround();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/qlf_k4n8_gpio_ctrl.md
Name: qlf_k4n8_gpio_ctrl

Overview:
- Register-mapped GPIO bank controller that sits directly upstream and downstream of a row of WIDTH `bidir` pad cells.
- Drives each cell's GPIO_IN (output data) and GPIO_EN (direction).
- Samples each cell's GPIO_OUT through a synchronizer and detects rising/falling edges.
- Raises a level interrupt from sticky, write-1-to-clear status bits.

Parameters:
- WIDTH, 8, number of pads in the bank (1..32).
- SYNC_STAGES, 2, flops in the input synchronizer (2..4).

Ports:
- clk  input  1  fabric clock; all state is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  register write strobe, single cycle.
- rd_en  input  1  register read strobe, single cycle.
- addr  input  3  register select.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  read data; valid when rd_valid=1.
- rd_valid  output  1  asserted exactly one cycle after an rd_en.
- gpio_in  output  WIDTH  to the bidir GPIO_IN pins (pad drive value).
- gpio_en  output  WIDTH  to the bidir GPIO_EN pins. 1 = pad is an input; 0 = pad drives GPIO_IN.
- gpio_out  input  WIDTH  from the bidir GPIO_OUT pins. Asynchronous; reads 0 while gpio_en=0.
- irq  output  1  OR of (STATUS); registered.

Behaviour:
- Register map:
  - 0 OUT (rw)
  - 1 DIR (rw; 1 = output)
  - 2 IN (ro; synchronized pad value)
  - 3 RISE_EN (rw)
  - 4 FALL_EN (rw)
  - 5 STATUS (W1C)
  - 6, 7 read as 0; writes to them are ignored.
- Pad outputs: gpio_in = OUT and gpio_en = ~DIR, both registered. Pad outputs update the cycle after the write.
- Reset (rst_n=0, asynchronous): all registers and synchronizer flops are 0. The resulting outputs are gpio_en = all 1s (every pad an input), gpio_in = 0, rdata = 0, rd_valid = 0, irq = 0, and the settle counter is loaded.
- Synchronizer: gpio_out passes through SYNC_STAGES flops to give s. A prev register holds s delayed by one cycle.
- Edge detection, per bit:
  - rise = s & ~prev & RISE_EN & ~DIR
  - fall = ~s & prev & FALL_EN & ~DIR
  - Any edge sets the STATUS bit, but only when the settle counter is 0.
- Pad-to-STATUS latency is SYNC_STAGES+1 cycles; irq follows STATUS one cycle later.
- Settle counter:
  - Loaded with SYNC_STAGES+1 on reset and on any DIR write.
  - Decrements to 0 and holds there.
  - While it is nonzero, edge detection is suppressed but s and prev keep updating. This prevents false edges at reset release and on output→input turnaround.
- STATUS write: wdata 1-bits clear the matching STATUS bits. If a set and a clear hit the same bit in the same cycle, set wins.
- Reads: rdata is registered, 1-cycle latency, with rd_valid pulsed for one cycle.
  - A read and a write in the same cycle return the pre-write value.
  - Back-to-back reads are accepted every cycle.
  - rdata holds its last value when rd_valid=0.
- IN register returns s for every bit. Bits in output mode therefore read 0, because the bidir cell masks them.
- Reset mid-operation: all state is cleared immediately and pads revert to input. Pending STATUS bits and an in-flight read are lost, and rd_valid=0.
- Write data bits above WIDTH do not exist; narrower use is by parameter only.

Test Plan:
1. Reset/defaults: hold rst_n=0 with gpio_out=8'hFF, then release → gpio_en=8'hFF, gpio_in=0, irq=0. STATUS reads 0 even after 10 cycles with RISE_EN=8'hFF written at cycle 1.
2. Output drive: write DIR=8'h0F, then OUT=8'hA5 → the next cycle gpio_en=8'hF0 and gpio_in=8'hA5. Read OUT → rd_valid one cycle later with rdata=8'hA5.
3. Rising edge: DIR=0, RISE_EN=8'h01, settle elapsed; raise gpio_out[0] at cycle T → STATUS[0]=1 at T+3 and irq=1 at T+4 (SYNC_STAGES=2).
4. W1C race: with STATUS=8'h03, write STATUS=8'h01 in the same cycle a falling edge (FALL_EN=8'h01) sets bit 0 → STATUS stays 8'h03; a later write of 8'h03 → STATUS=0 and irq=0 one cycle after.
5. Turnaround suppression: pad 2 is in output mode with the external pad high. Write DIR=0 with RISE_EN=8'h04 → no STATUS[2] set. A subsequent real falling then rising edge sets bit 2.
6. Async reset mid-read: assert rd_en, then drop rst_n between clock edges → rd_valid=0, gpio_en=all 1s and irq=0 immediately, without waiting for a clock edge.
